// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run controller for the 16-bit accumulator CPU and its single-port RAM.
//   The CPU is held in reset while the host loads or inspects RAM. On start,
//   the CPU is released and its program counter is watched. The run ends when
//   the program parks in a self-loop, the cycle budget runs out, or the host
//   aborts. This block also owns the RAM port multiplexer.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | host owns RAM, CPU held in reset, waits for host access/start
//   HRD   | host read: RAM data is back this cycle, ack + rvalid
//   RUN   | CPU released, RAM port passes CPU signals, cycle/halt tracking
//   HALT  | one-cycle gap with CPU in reset before returning to IDLE
//
// Ports
//   clk, rst            : clock (rising edge), async active-low reset
//   start, abort        : run control from host
//   busy, done, timeout : run status (done/timeout are levels until next start)
//   cycles              : RUN cycles of the last/current run
//   host_*              : host RAM access (req held until ack)
//   cpu_rst             : active-high reset to the CPU
//   cpu_wrEn/addr/wdata : CPU RAM port, cpu_pc : CPU program counter
//   ram_*               : shared RAM port
module cpu_run_ctrl #(
    parameter int unsigned SIZE        = 10,
    parameter int unsigned HALT_CYCLES = 16,
    parameter logic [31:0] MAX_CYCLES  = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [31:0]     cycles,
    input  logic            host_req,
    input  logic            host_we,
    input  logic [SIZE-1:0] host_addr,
    input  logic [15:0]     host_wdata,
    output logic            host_ack,
    output logic            host_rvalid,
    output logic [15:0]     host_rdata,
    output logic            cpu_rst,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [15:0]     cpu_wdata,
    input  logic [SIZE-1:0] cpu_pc,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [15:0]     ram_wdata,
    input  logic [15:0]     ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HRD  = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam int unsigned   SW       = $clog2(HALT_CYCLES + 1);
    localparam logic [SW-1:0] HALT_CNT = SW'(HALT_CYCLES);

    state_t          state, state_nxt;
    logic [SIZE-1:0] pc_q;
    logic [SW-1:0]   stable, stable_nxt;
    logic [31:0]     cycles_inc;
    logic            run_start, run_end, end_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            timeout <= 1'b0;
            cycles  <= '0;
            pc_q    <= '0;
            stable  <= '0;
        end else begin
            state <= state_nxt;
            if (run_start) begin
                done    <= 1'b0;
                timeout <= 1'b0;
                cycles  <= '0;
                pc_q    <= '0;
                stable  <= '0;
            end
            if (state == S_RUN) begin
                cycles <= cycles_inc;
                pc_q   <= cpu_pc;
                stable <= stable_nxt;
                // done is visible already during the HALT cycle
                if (run_end) begin
                    done    <= 1'b1;
                    timeout <= end_timeout;
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        cpu_rst     = 1'b1;
        host_ack    = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = '0;
        ram_wrEn    = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        run_start   = 1'b0;
        run_end     = 1'b0;
        end_timeout = 1'b0;
        cycles_inc  = cycles + 32'd1;
        stable_nxt  = (cpu_pc == pc_q) ? stable + SW'(1) : '0;

        case (state)
            S_IDLE: begin
                // a pending host access always wins over start
                if (host_req) begin
                    ram_addr = host_addr;
                    if (host_we) begin
                        ram_wrEn  = 1'b1;
                        ram_wdata = host_wdata;
                        host_ack  = 1'b1;
                    end else begin
                        state_nxt = S_HRD;
                    end
                end else if (start) begin
                    run_start = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_HRD: begin
                ram_addr    = host_addr;
                host_ack    = 1'b1;
                host_rvalid = 1'b1;
                host_rdata  = ram_rdata;
                state_nxt   = S_IDLE;
            end
            S_RUN: begin
                busy      = 1'b1;
                cpu_rst   = 1'b0;
                ram_wrEn  = cpu_wrEn;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                if (abort) begin
                    run_end     = 1'b1;
                    end_timeout = 1'b1;
                end else if (cycles_inc == MAX_CYCLES) begin
                    run_end     = 1'b1;
                    end_timeout = 1'b1;
                end else if (stable_nxt == HALT_CNT) begin
                    run_end = 1'b1;
                end
                if (run_end) state_nxt = S_HALT;
            end
            S_HALT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // while reset is held, nothing may reach the RAM or the host,
        // even if a host request is already pending
        if (!rst) begin
            busy        = 1'b0;
            cpu_rst     = 1'b1;
            host_ack    = 1'b0;
            host_rvalid = 1'b0;
            host_rdata  = '0;
            ram_wrEn    = 1'b0;
            ram_addr    = '0;
            ram_wdata   = '0;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    localparam int SIZE = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            start, abort;
    logic            busy, done, timeout;
    logic [31:0]     cycles;
    logic            host_req, host_we;
    logic [SIZE-1:0] host_addr;
    logic [15:0]     host_wdata;
    logic            host_ack, host_rvalid;
    logic [15:0]     host_rdata;
    logic            cpu_rst;
    logic            cpu_wrEn;
    logic [SIZE-1:0] cpu_addr;
    logic [15:0]     cpu_wdata;
    logic [SIZE-1:0] cpu_pc;
    logic            ram_wrEn;
    logic [SIZE-1:0] ram_addr;
    logic [15:0]     ram_wdata;
    logic [15:0]     ram_rdata;

    cpu_run_ctrl #(.SIZE(SIZE), .HALT_CYCLES(16), .MAX_CYCLES(32'd100)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .timeout(timeout), .cycles(cycles),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .cpu_rst(cpu_rst), .cpu_wrEn(cpu_wrEn),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc),
        .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // synchronous single-port RAM, read data one cycle after address
    logic [15:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_wrEn) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_cnt  = 0;
    int rc       = 0;
    int prof     = 0;

    always @(posedge clk) cyc++;

    // program-counter stimulus: profile 0 fetches @0 twice then parks @1,
    // profile 1 moves every cycle and never parks
    always @(posedge clk) begin
        #1;
        if (busy) begin
            rc++;
            if (prof != 0) cpu_pc = SIZE'(rc % 16);
            else           cpu_pc = (rc <= 2) ? SIZE'(0) : SIZE'(1);
        end else begin
            rc     = 0;
            cpu_pc = '0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic [15:0] rdata;
        int          lat;
        int          cyc;
        string       nm;
    } host_exp_t;

    typedef struct {
        logic to;
        int   cyc;
    } run_exp_t;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } hvec_t;

    host_exp_t host_q[$];
    run_exp_t  run_q[$];
    hvec_t     hv[14];

    // scoreboard side: every host ack consumes one expectation
    always @(negedge clk) begin
        if (host_ack) begin
            host_exp_t e;
            ack_cnt++;
            if (host_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL host_unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                e = host_q.pop_front();
                check({e.nm, "_rvalid"}, 32'(host_rvalid), 32'(e.rd));
                if (e.rd) check({e.nm, "_rdata"}, 32'(host_rdata), 32'(e.rdata));
                if (e.lat >= 0) check({e.nm, "_latency"}, 32'(cyc - e.cyc), 32'(e.lat));
            end
        end
    end

    task automatic wait_ack(input int c0, input string nm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (ack_cnt != c0) break;
        end
        if (ack_cnt == c0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_ack_wait: got no ack expected ack within 20 cycles", nm);
        end
        @(posedge clk); #2;
        host_req = 1'b0;
        host_we  = 1'b0;
    endtask

    task automatic host_xfer(input logic we, input logic [9:0] a, input logic [15:0] wd,
                             input logic [15:0] exp_rd, input int exp_lat, input string nm);
        host_exp_t e;
        int c0;
        e.rd = !we; e.rdata = exp_rd; e.lat = exp_lat; e.cyc = cyc; e.nm = nm;
        host_q.push_back(e);
        c0         = ack_cnt;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = wd;
        wait_ack(c0, nm);
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            host_xfer(hv[i].we, hv[i].addr, hv[i].wdata, hv[i].rdata,
                      hv[i].we ? 0 : 1, $sformatf("vec%0d", i));
    endtask

    int held_c0;

    task automatic run_prog(input int p, input int abort_at, input logic hold,
                            input logic exp_to, input int exp_cyc, input string nm);
        run_exp_t r;
        int nb;
        logic ack_in_run;
        r.to = exp_to; r.cyc = exp_cyc;
        run_q.push_back(r);
        prof = p;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check({nm, "_start_busy"}, 32'(busy), 32'd1);
        check({nm, "_start_cpu_rst"}, 32'(cpu_rst), 32'd0);
        check({nm, "_start_done_clr"}, 32'(done), 32'd0);
        if (hold) begin
            host_exp_t e;
            e.rd = 1'b1; e.rdata = 16'h8006; e.lat = -1; e.cyc = cyc; e.nm = {nm, "_held"};
            host_q.push_back(e);
            held_c0   = ack_cnt;
            host_req  = 1'b1;
            host_we   = 1'b0;
            host_addr = 10'd1;
        end
        nb = 0;
        ack_in_run = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            nb++;
            if (host_ack) ack_in_run = 1'b1;
            abort = (abort_at != 0) && (nb == abort_at);
            @(posedge clk); #2;
        end
        abort = 1'b0;
        r = run_q.pop_front();
        check({nm, "_busy_cycles"}, 32'(nb), 32'(r.cyc));
        check({nm, "_halt_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_timeout"}, 32'(timeout), 32'(r.to));
        check({nm, "_cycles"}, cycles, 32'(r.cyc));
        if (hold) check({nm, "_no_ack_in_run"}, 32'(ack_in_run), 32'd0);
    endtask

    initial begin
        hv[0]  = '{1'b1, 10'd0, 16'hA005, 16'h0000};
        hv[1]  = '{1'b1, 10'd1, 16'h8006, 16'h0000};
        hv[2]  = '{1'b1, 10'd5, 16'h0000, 16'h0000};
        hv[3]  = '{1'b1, 10'd6, 16'h0001, 16'h0000};
        hv[4]  = '{1'b0, 10'd1, 16'h0000, 16'h8006};
        hv[5]  = '{1'b0, 10'd0, 16'h0000, 16'hA005};
        hv[6]  = '{1'b0, 10'd6, 16'h0000, 16'h0001};
        hv[7]  = '{1'b0, 10'd5, 16'h0000, 16'h0000};
        hv[8]  = '{1'b1, 10'd0, 16'h0000, 16'h0000};
        hv[9]  = '{1'b1, 10'd4, 16'h0002, 16'h0000};
        hv[10] = '{1'b1, 10'd1, 16'h8003, 16'h0000};
        hv[11] = '{1'b1, 10'd3, 16'h0000, 16'h0000};
        hv[12] = '{1'b0, 10'd1, 16'h0000, 16'h8003};
        hv[13] = '{1'b0, 10'd0, 16'h0000, 16'h0000};

        rst = 1'b0; start = 1'b0; abort = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_pc = '0;

        // reset values, with a host write pending that must not leak through
        @(posedge clk); #2;
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'd3; host_wdata = 16'hFFFF;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_cycles", cycles, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_host_ack", 32'(host_ack), 32'd0);
        check("rst_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        check("rst_ram_wrEn", 32'(ram_wrEn), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        host_req = 1'b0; host_we = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;

        // load park program and read it back
        apply_vecs(0, 7);

        // parking run, with a host read held throughout
        run_prog(0, 0, 1'b1, 1'b0, 19, "halt");
        wait_ack(held_c0, "held_req");
        check("done_level_idle", 32'(done), 32'd1);

        // never-parking program
        apply_vecs(8, 13);

        // start together with host_req: read wins, start ignored
        begin
            host_exp_t e;
            int c0;
            e.rd = 1'b1; e.rdata = 16'h0002; e.lat = 1; e.cyc = cyc; e.nm = "start_w_req";
            host_q.push_back(e);
            c0 = ack_cnt;
            host_req = 1'b1; host_we = 1'b0; host_addr = 10'd4; start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
            check("start_w_req_busy", 32'(busy), 32'd0);
            check("start_w_req_done_kept", 32'(done), 32'd1);
            for (int i = 0; i < 20; i++) begin
                if (ack_cnt != c0) break;
                @(negedge clk); #1;
            end
            check("start_w_req_acked", 32'(ack_cnt - c0), 32'd1);
            @(posedge clk); #2;
            host_req = 1'b0;
            @(posedge clk); #2;
            check("start_w_req_still_idle", 32'(busy), 32'd0);
        end

        run_prog(1, 0, 1'b0, 1'b1, 100, "maxcyc");
        @(posedge clk); #2;
        run_prog(1, 7, 1'b0, 1'b1, 7, "abort");
        @(posedge clk); #2;

        // async reset in the middle of a CPU write
        prof = 1;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        cpu_addr = 10'd9; cpu_wdata = 16'hDEAD; cpu_wrEn = 1'b1;
        #1;
        check("run_pass_wrEn", 32'(ram_wrEn), 32'd1);
        check("run_pass_addr", 32'(ram_addr), 32'd9);
        check("run_pass_wdata", 32'(ram_wdata), 32'hDEAD);
        rst = 1'b0;
        #1;
        check("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ram_wrEn", 32'(ram_wrEn), 32'd0);
        check("arst_cycles", cycles, 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1; cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        @(posedge clk); #2;
        host_xfer(1'b0, 10'd9, 16'h0, 16'h0000, 1, "arst_no_write");
        host_xfer(1'b0, 10'd1, 16'h0, 16'h8003, 1, "arst_ram_kept");

        check("host_q_drained", 32'(host_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the 16-bit accumulator CPU and its shared single-port RAM. It holds the CPU in reset while a host loads or inspects RAM, then releases the CPU and monitors its program counter. It declares completion when the program parks in a self-loop, the cycle budget expires, or the host aborts. It sits between the host/testbench, the CPU and the RAM, and owns the RAM port multiplexer.

## Interface
- SIZE, 10, RAM address width (matches CPU `addr_toRAM`/`pCounter`)
- HALT_CYCLES, 16, consecutive RUN cycles with unchanged `cpu_pc` that constitute a halt (must be ≥ 5)
- MAX_CYCLES, 32'hFFFF_FFFF, RUN cycle budget before forced timeout
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse, begin program run
- abort  in  1  force end of run
- busy  out  1  high while in RUN
- done  out  1  level; set on run end, cleared by next accepted start
- timeout  out  1  level; set when run ended by MAX_CYCLES or abort, cleared by next accepted start
- cycles  out  32  RUN cycles of last/current run
- host_req  in  1  host RAM access request, held until ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  SIZE  host RAM address
- host_wdata  in  16  host write data
- host_ack  out  1  access accepted/completed
- host_rvalid  out  1  host_rdata valid
- host_rdata  out  16  read data
- cpu_rst  out  1  to CPU `rst`, active-high
- cpu_wrEn  in  1  from CPU
- cpu_addr  in  SIZE  from CPU
- cpu_wdata  in  16  from CPU
- cpu_pc  in  SIZE  CPU program counter
- ram_wrEn  out  1  to RAM
- ram_addr  out  SIZE  to RAM
- ram_wdata  out  16  to RAM
- ram_rdata  in  16  RAM read data, valid one cycle after address

## Operation
- States: IDLE, HRD (host read wait), RUN, HALT.
- Reset: state IDLE; done=0, timeout=0, cycles=0, busy=0, host_ack=0, host_rvalid=0, host_rdata=0, ram_wrEn=0, ram_addr=0, ram_wdata=0, cpu_rst=1.
- cpu_rst = 1 in every state except RUN.
- IDLE: host owns RAM.
  - host_req & host_we → ram_wrEn=1, ram_addr=host_addr, ram_wdata=host_wdata, host_ack=1, same cycle; stay IDLE.
  - host_req & !host_we → ram_addr=host_addr; go HRD.
  - start & !host_req → clear done/timeout/cycles/pc tracker; go RUN.
  - start with host_req high is ignored; host_req has priority.
- HRD: host_ack=1, host_rvalid=1, host_rdata=ram_rdata; go IDLE. start is ignored.
- RUN: RAM port passes through CPU signals combinationally. host_req is never acked (host keeps holding it). start is ignored. busy=1. cycles increments every RUN cycle.
- Halt tracker: pc_q registers cpu_pc each RUN cycle; stable count resets when cpu_pc≠pc_q, else increments. When stable count reaches HALT_CYCLES → HALT, timeout=0.
- cycles == MAX_CYCLES, or abort → HALT with timeout=1. Priority: abort > MAX_CYCLES > halt.
- HALT: one cycle; set done; go IDLE. RAM port idle (ram_wrEn=0).

## Timing
- start sampled at edge k → RUN in cycle k+1; CPU sees rst=0 from k+1 and fetches address 0 that cycle.
- Host write: 1 cycle. Host read: 2 cycles, ack+rvalid in second.
- cycles counts clocks spent in RUN, excluding HALT; it holds its value in IDLE.
- CPU is guaranteed ≥1 cycle of cpu_rst=1 (HALT) between runs.
- Async rst mid-RUN: immediately IDLE, cpu_rst=1, all outputs at reset values; in-flight CPU write is dropped.

## Test plan
- Host writes 0xA005@0, 0x8006@1, 0x0000@5, 0x0001@6, then reads @1 → ack+rvalid one cycle after request, rdata=0x8006.
- Same program, start pulse (HALT_CYCLES=16) → busy for 19 cycles, done=1, timeout=0, cycles=19, cpu_rst high again.
- Program of ADD loop never parking (0x0000@0 with mem[4]=2, 0x8003@1 with mem[3]=0, W≠0), MAX_CYCLES=100 → done=1, timeout=1, cycles=100.
- abort asserted at RUN cycle 7 → HALT next cycle, done=1, timeout=1, cycles=7.
- host_req held during RUN → no host_ack until after HALT; the request is then served in IDLE. start together with host_req in IDLE → ignored, busy stays 0.
- Async rst low mid-RUN → cpu_rst=1 and busy=0 without waiting for a clock edge; a CPU CPfW in that cycle is not written.
